// File: rtl/inst_issue_pkg.sv
// Shared types for the instruction fetch/issue front end: raw word layout,
// decoded instruction format and the issue controller state encoding.
package inst_issue_pkg;

  localparam int NUM_INSTRUCTIONS_WIDTH = 8;
  localparam int INSTRUCTION_WIDTH      = 24;

  // Raw instruction word: {opcode[23:20], param[19:16], data[15:0]}
  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  param;
    logic [15:0] data;
  } RawInst;

  localparam logic [3:0] RAW_OP_RENDER     = 4'h1;
  localparam logic [3:0] RAW_OP_CAMERA_SET = 4'h2;
  localparam logic [3:0] RAW_OP_FRAME      = 4'h3;

  // Camera parameter selectors carried in the param field
  localparam logic [3:0] cpXLocation = 4'h0;
  localparam logic [3:0] cpYLocation = 4'h1;

  typedef enum logic [3:0] {
    opRender      = 4'h0,
    opCameraSet   = 4'h1,
    opFrame       = 4'h2,
    opUnsupported = 4'hF
  } IType;

  typedef struct packed {
    IType        iType;
    logic [3:0]  cParam;
    logic [15:0] data;
  } DecodedInst;

  localparam int DECODED_INSTRUCTION_WIDTH = $bits(DecodedInst);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_FRAME_WAIT,
    S_DONE
  } IssueState;

  // True when fp addresses the final instruction of a len-long program
  function automatic logic fp_is_last(input logic [NUM_INSTRUCTIONS_WIDTH-1:0] fp,
                                      input logic [NUM_INSTRUCTIONS_WIDTH-1:0] len);
    return !(fp < (len - 1'b1));
  endfunction

endpackage

// File: rtl/inst_issue_decoder.sv
// Combinational raw-word to DecodedInst decoder; unknown opcodes become
// opUnsupported with zeroed payload.
module inst_decoder
  import inst_issue_pkg::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0]         inst_word,
  output logic [DECODED_INSTRUCTION_WIDTH-1:0] d_inst
);

  RawInst     raw;
  DecodedInst dec;

  assign raw    = RawInst'(inst_word);
  assign d_inst = dec;

  // Opcode lookup; payload passes through only for recognised opcodes
  always_comb begin
    dec       = '0;
    dec.iType = opUnsupported;
    case (raw.opcode)
      RAW_OP_RENDER: begin
        dec.iType  = opRender;
        dec.cParam = raw.param;
        dec.data   = raw.data;
      end
      RAW_OP_CAMERA_SET: begin
        dec.iType  = opCameraSet;
        dec.cParam = raw.param;
        dec.data   = raw.data;
      end
      RAW_OP_FRAME: begin
        dec.iType  = opFrame;
        dec.cParam = raw.param;
        dec.data   = raw.data;
      end
      default: dec.iType = opUnsupported;
    endcase
  end

endmodule

// File: rtl/inst_issue.sv
// Instruction fetch/issue front end: walks the ROM, decodes each word and
// hands it to execute one strobe at a time, honouring memory_ready and
// holding off after every frame commit.
module inst_issue
  import inst_issue_pkg::*;
#(
  parameter int ROM_LATENCY = 2,
  parameter int LOOP        = 1
) (
  input  logic                                 clk_50mhz,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [NUM_INSTRUCTIONS_WIDTH-1:0]    prog_len,
  output logic [NUM_INSTRUCTIONS_WIDTH-1:0]    inst_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]         inst_data,
  input  logic                                 memory_ready,
  output logic                                 dInst_valid,
  output logic [DECODED_INSTRUCTION_WIDTH-1:0] dInst,
  output logic [NUM_INSTRUCTIONS_WIDTH-1:0]    pc,
  output logic                                 busy,
  output logic                                 halted,
  output logic                                 unsupported_err
);

  IssueState state_reg, state_next, adv_state;

  logic [2:0]                        cnt_reg;
  logic [NUM_INSTRUCTIONS_WIDTH-1:0] fp_reg, len_reg, fp_adv;
  logic [NUM_INSTRUCTIONS_WIDTH-1:0] inst_addr_reg, pc_reg;
  DecodedInst                        dec_reg, dinst_reg, fetched;
  logic [DECODED_INSTRUCTION_WIDTH-1:0] fetched_word;
  logic                              dinst_valid_reg, err_reg, fw_skip_reg;

  logic fetch_last, do_start, do_issue, do_skip, do_advance, is_frame, is_unsup;

  inst_decoder u_decoder (
    .inst_word (inst_data),
    .d_inst    (fetched_word)
  );

  assign fetched = DecodedInst'(fetched_word);

  // State register; reset wins over everything, including start
  always_ff @(posedge clk_50mhz) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state selection from the decoded control events
  always_comb begin
    state_next = state_reg;
    if (do_start)                state_next = S_FETCH;
    else if (fetch_last)         state_next = S_ISSUE;
    else if (do_issue && is_frame) state_next = S_FRAME_WAIT;
    else if (do_advance)         state_next = adv_state;
  end

  // Control events and status outputs derived from the current state
  always_comb begin
    is_frame   = (dec_reg.iType == opFrame);
    is_unsup   = (dec_reg.iType == opUnsupported);
    busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    halted     = (state_reg == S_DONE);
    // Address register moves at the transition edge, so the ROM word is
    // sampled ROM_LATENCY+1 edges into FETCH
    fetch_last = (state_reg == S_FETCH) && (cnt_reg == 3'(ROM_LATENCY));
    do_start   = !busy && start && (prog_len != '0);
    do_skip    = (state_reg == S_ISSUE) && is_unsup;
    do_issue   = (state_reg == S_ISSUE) && !is_unsup && memory_ready;
    do_advance = do_skip || (do_issue && !is_frame) ||
                 ((state_reg == S_FRAME_WAIT) && !fw_skip_reg && memory_ready);
    if (!fp_is_last(fp_reg, len_reg)) begin
      fp_adv    = fp_reg + 1'b1;
      adv_state = S_FETCH;
    end else begin
      fp_adv    = '0;
      adv_state = (LOOP == 1) ? S_FETCH : S_DONE;
    end
  end

  // Datapath: fetch pointer, ROM address, decoded word and issue registers
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      cnt_reg         <= '0;
      fp_reg          <= '0;
      len_reg         <= '0;
      inst_addr_reg   <= '0;
      pc_reg          <= '0;
      dec_reg         <= '0;
      dinst_reg       <= '0;
      dinst_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      fw_skip_reg     <= 1'b0;
    end else begin
      dinst_valid_reg <= do_issue;
      // One-cycle blind window after a frame issue lets execute drop ready
      fw_skip_reg     <= do_issue && is_frame;
      if (state_reg == S_FETCH) cnt_reg <= cnt_reg + 3'd1;
      if (fetch_last) dec_reg <= fetched;
      if (do_start) begin
        len_reg       <= prog_len;
        fp_reg        <= '0;
        inst_addr_reg <= '0;
        cnt_reg       <= '0;
      end
      if (do_issue) begin
        dinst_reg <= dec_reg;
        pc_reg    <= fp_reg;
      end
      if (do_skip) err_reg <= 1'b1;
      if (do_advance && (adv_state == S_FETCH)) begin
        fp_reg        <= fp_adv;
        inst_addr_reg <= fp_adv;
        cnt_reg       <= '0;
      end
    end
  end

  assign inst_addr       = inst_addr_reg;
  assign dInst_valid     = dinst_valid_reg;
  assign dInst           = dinst_reg;
  assign pc              = pc_reg;
  assign unsupported_err = err_reg;

endmodule

// File: doc/inst_issue.md
# inst_issue

Instruction fetch/issue front end for `execute`. Reads the raw program from the instruction ROM, decodes each word into a `DecodedInst`, and presents it to `execute` as `dInst_valid`/`dInst`/`pc`. Each issue is gated on `execute`'s `memory_ready`, and the block stalls across frame commits. It runs on the 50 MHz instruction-side clock, alongside `execute`'s `clk_50mhz` domain.

## Interface
- `ROM_LATENCY`, default 2: read latency of the instruction ROM, in cycles from `inst_addr` to valid `inst_data`. Legal range is 1–4.
- `LOOP`, default 1: 1 wraps `pc` to 0 after the last instruction; 0 halts.

- `clk_50mhz`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins execution at `pc` = 0
- `prog_len`  in  NUM_INSTRUCTIONS_WIDTH  number of instructions; sampled on accepted `start`
- `inst_addr`  out  NUM_INSTRUCTIONS_WIDTH  ROM read address (registered)
- `inst_data`  in  INSTRUCTION_WIDTH  ROM read data
- `memory_ready`  in  1  from `execute`; an instruction may be issued only while high
- `dInst_valid`  out  1  one-cycle issue strobe
- `dInst`  out  DECODED_INSTRUCTION_WIDTH  `DecodedInst`; held stable until the next issue
- `pc`  out  NUM_INSTRUCTIONS_WIDTH  index of the instruction carried by `dInst`
- `busy`  out  1  high in every state except IDLE and DONE
- `halted`  out  1  high in DONE
- `unsupported_err`  out  1  sticky; set when an `opUnsupported` word is fetched

## Operation
- **States:** IDLE, FETCH, ISSUE, FRAME_WAIT, DONE.
- **IDLE:**
  - `start` with `prog_len` != 0 latches `prog_len`, sets fetch pointer `fp` = 0, and moves to FETCH.
  - `start` with `prog_len` == 0 is ignored.
- **FETCH:**
  - Drives `inst_addr` = `fp` and counts ROM_LATENCY cycles.
  - On the last count, it registers `inst_data` through `inst_decoder` and moves to ISSUE.
- **ISSUE:**
  - Waits for `memory_ready` = 1.
  - In the cycle it sees `memory_ready` = 1, it registers `dInst_valid` = 1, `dInst`, and `pc` = `fp`.
  - Then it advances: if the issued `iType` is `opFrame`, it goes to FRAME_WAIT; otherwise it goes to NEXT.
- **`opUnsupported` fetched:**
  - The word is not issued and `dInst_valid` stays 0.
  - `unsupported_err` is set, and the block goes directly to NEXT.
- **FRAME_WAIT:**
  - `memory_ready` is ignored for exactly 1 cycle, giving `execute` time to drop it.
  - The block then waits for `memory_ready` = 1 and goes to NEXT.
- **NEXT** (a transition, not a state):
  - If `fp` < `prog_len`−1: `fp`+1, go to FETCH.
  - Else if LOOP = 1: `fp` = 0, go to FETCH.
  - Else: go to DONE.
- **DONE:** holds `dInst` and `pc`. `start` restarts from `pc` = 0 with a freshly sampled `prog_len`.
- `start` is ignored while `busy` = 1.
- **Reset at any time:**
  - Returns to IDLE.
  - Clears `unsupported_err`.
  - Zeroes every output. Any in-flight ROM data is discarded.
- `pc` and `fp` arithmetic is modulo 2^NUM_INSTRUCTIONS_WIDTH. `prog_len` = 2^NUM_INSTRUCTIONS_WIDTH is not representable; the maximum program is 2^N−1 instructions.

## Timing
- **Reset values:** `dInst_valid` 0, `dInst` all zeros, `pc` 0, `inst_addr` 0, `busy` 0, `halted` 0, `unsupported_err` 0.
- **Start latency:** `start` high at edge k puts `inst_addr` = 0 valid from edge k+1. With `memory_ready` = 1, the first `dInst_valid` is high in the cycle after edge k+ROM_LATENCY+2.
- **Steady-state throughput:** with `memory_ready` held high and no `opFrame`, one issue every ROM_LATENCY+2 cycles.
- `dInst_valid` is never high in two consecutive cycles.
- `dInst` and `pc` change only on the edge that raises `dInst_valid`.
- **`memory_ready` low in ISSUE:** stall indefinitely with no timeout. Issue occurs on the cycle after `memory_ready` is sampled high.
- **Reset priority:** `rst` has priority over `start` in the same cycle.

## Structure
- **Additions to `proctypes`:**
  - `INSTRUCTION_WIDTH` and the raw instruction field layout.
  - An `IssueState` enum.
  - Reuse of `DecodedInst`, `NUM_INSTRUCTIONS_WIDTH`, `DECODED_INSTRUCTION_WIDTH`, and the `opFrame`/`opUnsupported` `iType` values.
- **Sub-module:** one combinational `inst_decoder` (raw word to `DecodedInst`; unknown opcodes map to `opUnsupported`). It is instantiated once and reused by other benches.

## Test plan
- **Basic issue:** `prog_len` = 3, ROM = {`opRender`, `opCameraSet` `cpXLocation` 16'hAAAA, `opCameraSet` `cpYLocation` 16'h00FF}, `memory_ready` = 1, LOOP = 0 → three `dInst_valid` pulses with `pc` = 0, 1, 2 and matching `dInst`, spaced ROM_LATENCY+2 cycles apart; then `halted` = 1 and `busy` = 0.
- **Frame stall:** ROM = {`opFrame`, `opCameraSet` 16'h0FF0}, `memory_ready` dropped for 5 cycles one cycle after the `opFrame` issue → no issue of `pc` = 1 until `memory_ready` has been high for 1 cycle.
- **Unsupported word:** `prog_len` = 3 with the middle word an unknown opcode → issues only `pc` = 0 and `pc` = 2; `unsupported_err` = 1 and stays 1 through DONE.
- **Loop wrap:** LOOP = 1, `prog_len` = 2 → `pc` sequence 0, 1, 0, 1…; `halted` never asserts.
- **Reset mid-fetch:** `rst` pulsed during FETCH of `pc` = 1 → next cycle all outputs are at their reset values and no `dInst_valid` occurs. A subsequent `start` issues from `pc` = 0.
- **Ignored start:** `start` with `prog_len` = 0 → remains IDLE, `busy` = 0. `start` re-pulsed while `busy` = 1 → no effect on the `pc` sequence.
